// File: rtl/rx_deser_param.sv
// Serial-to-parallel deserializer with run-time frame length, selectable bit order and
// valid/ready output handshake. Optional parity accumulator enabled by RX_DESER_PARITY_EN.
module rx_deser_param #(
    parameter int unsigned MAX_WIDTH = 9,
    parameter int unsigned LEN_W     = $clog2(MAX_WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sampled_data_bit_i,
    input  logic                 deser_en_i,
    input  logic                 frame_start_i,
    input  logic [LEN_W-1:0]     data_len_i,
    input  logic                 msb_first_i,
    input  logic                 data_ready_i,
    output logic [MAX_WIDTH-1:0] p_data_o,
    output logic                 data_valid_o,
    output logic                 overrun_o,
    output logic                 busy_o,
    output logic [LEN_W-1:0]     bit_cnt_o,
    output logic                 par_calc_o
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e               state_q, state_d;
    logic [MAX_WIDTH-1:0] sreg_q, sreg_d;
    logic [MAX_WIDTH-1:0] sreg_next;
    logic [MAX_WIDTH-1:0] p_data_q, p_data_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     cnt_inc;
    logic [LEN_W-1:0]     len_clamped;
    logic                 ord_q, ord_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    assign cnt_inc = cnt_q + LEN_W'(1);

    always_comb begin
        len_clamped = data_len_i;
        if (data_len_i == '0) begin
            len_clamped = LEN_W'(1);
        end else if (data_len_i > LEN_W'(MAX_WIDTH)) begin
            len_clamped = LEN_W'(MAX_WIDTH);
        end
    end

    // Shift register value after accepting the current bit, in the latched order.
    always_comb begin
        sreg_next = sreg_q;
        if (ord_q) begin
            sreg_next = {sreg_q[MAX_WIDTH-2:0], sampled_data_bit_i};
        end else begin
            for (int i = 0; i < int'(MAX_WIDTH); i++) begin
                if (LEN_W'(i) == cnt_q) begin
                    sreg_next[i] = sampled_data_bit_i;
                end
            end
        end
    end

    logic frame_done;
    assign frame_done = (state_q == StShift) && !frame_start_i && deser_en_i && (cnt_inc == len_q);

`ifdef RX_DESER_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic par_calc_q, par_calc_d;

    always_comb begin
        par_acc_d  = par_acc_q;
        par_calc_d = par_calc_q;
        if (frame_start_i) begin
            par_acc_d = 1'b0;
        end else if (state_q == StShift && deser_en_i) begin
            par_acc_d = par_acc_q ^ sampled_data_bit_i;
            if (frame_done) begin
                par_calc_d = par_acc_q ^ sampled_data_bit_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_acc_q  <= 1'b0;
            par_calc_q <= 1'b0;
        end else begin
            par_acc_q  <= par_acc_d;
            par_calc_q <= par_calc_d;
        end
    end

    assign par_calc_o = par_calc_q;
`else
    assign par_calc_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        p_data_d  = p_data_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ord_d     = ord_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && data_ready_i) begin
            valid_d = 1'b0;
        end

        // A frame start always wins, including over a coincident strobe.
        if (frame_start_i) begin
            state_d = StShift;
            sreg_d  = '0;
            cnt_d   = '0;
            len_d   = len_clamped;
            ord_d   = msb_first_i;
        end else if (state_q == StShift && deser_en_i) begin
            sreg_d = sreg_next;
            cnt_d  = cnt_inc;
            if (frame_done) begin
                state_d   = StIdle;
                p_data_d  = sreg_next;
                valid_d   = 1'b1;
                overrun_d = valid_q && !data_ready_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            sreg_q    <= '0;
            p_data_q  <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            ord_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            p_data_q  <= p_data_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ord_q     <= ord_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign p_data_o     = p_data_q;
    assign data_valid_o = valid_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q == StShift);
    assign bit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_rx_deser_param.sv
// Directed self-checking bench for rx_deser_param; parity expectations follow
// whether RX_DESER_PARITY_EN is defined.
module tb_rx_deser_param;

    localparam int unsigned MAX_WIDTH = 9;
    localparam int unsigned LEN_W     = $clog2(MAX_WIDTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 bit_in = 1'b0;
    logic                 deser_en = 1'b0;
    logic                 frame_start = 1'b0;
    logic [LEN_W-1:0]     data_len = '0;
    logic                 msb_first = 1'b0;
    logic                 data_ready = 1'b0;
    logic [MAX_WIDTH-1:0] p_data;
    logic                 data_valid;
    logic                 overrun;
    logic                 busy;
    logic [LEN_W-1:0]     bit_cnt;
    logic                 par_calc;

    int total = 0;
    int bad   = 0;

    rx_deser_param #(
        .MAX_WIDTH(MAX_WIDTH),
        .LEN_W    (LEN_W)
    ) u_dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .sampled_data_bit_i(bit_in),
        .deser_en_i        (deser_en),
        .frame_start_i     (frame_start),
        .data_len_i        (data_len),
        .msb_first_i       (msb_first),
        .data_ready_i      (data_ready),
        .p_data_o          (p_data),
        .data_valid_o      (data_valid),
        .overrun_o         (overrun),
        .busy_o            (busy),
        .bit_cnt_o         (bit_cnt),
        .par_calc_o        (par_calc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_par(input logic [15:0] w);
`ifdef RX_DESER_PARITY_EN
        return ^w;
`else
        return 1'b0 & w[0];
`endif
    endfunction

    task automatic start_frame(input logic [LEN_W-1:0] len, input logic msb);
        frame_start = 1'b1;
        data_len    = len;
        msb_first   = msb;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic strobe(input logic b);
        deser_en = 1'b1;
        bit_in   = b;
        @(negedge clk);
        deser_en = 1'b0;
    endtask

    // seq[i] is the i-th bit on the wire.
    task automatic send(input logic [LEN_W-1:0] len, input logic msb, input logic [15:0] seq,
                        input int n);
        start_frame(len, msb);
        for (int i = 0; i < n; i++) strobe(seq[i]);
    endtask

    task automatic consume(input string tag);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check(tag, 32'(data_valid), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_p_data", 32'(p_data), 32'h0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check("rst_par", 32'(par_calc), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // idle strobes are ignored
        strobe(1'b1);
        check("idle_cnt", 32'(bit_cnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // LSB-first 8 bits, checked one cycle before and after the last strobe
        start_frame(4'd8, 1'b0);
        check("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 7; i++) strobe(logic'((16'h004D >> i) & 16'h1));
        check("lsb_pre_valid", 32'(data_valid), 32'd0);
        check("lsb_pre_cnt", 32'(bit_cnt), 32'd7);
        strobe(1'b0);
        check("lsb_p_data", 32'(p_data), 32'h04D);
        check("lsb_valid", 32'(data_valid), 32'd1);
        check("lsb_busy", 32'(busy), 32'd0);
        check("lsb_cnt", 32'(bit_cnt), 32'd8);
        check("lsb_par", 32'(par_calc), 32'(exp_par(16'h004D)));
        consume("lsb_consume");
        check("lsb_hold", 32'(p_data), 32'h04D);

        send(4'd8, 1'b1, 16'h004D, 8);
        check("msb_p_data", 32'(p_data), 32'h0B2);
        check("msb_valid", 32'(data_valid), 32'd1);
        consume("msb_consume");

        send(4'd5, 1'b0, 16'h0017, 5);
        check("len5_p_data", 32'(p_data), 32'h017);
        check("len5_par", 32'(par_calc), 32'(exp_par(16'h0017)));
        consume("len5_consume");

        // overrun: B completes while A is still pending
        send(4'd8, 1'b0, 16'h0055, 8);
        check("ovr_a_valid", 32'(data_valid), 32'd1);
        send(4'd8, 1'b0, 16'h00AA, 8);
        check("ovr_p_data", 32'(p_data), 32'h0AA);
        check("ovr_valid", 32'(data_valid), 32'd1);
        check("ovr_pulse", 32'(overrun), 32'd1);
        @(negedge clk);
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        check("ovr_valid_hold", 32'(data_valid), 32'd1);
        consume("ovr_consume");

        // consumer takes A on B's completion edge
        send(4'd8, 1'b0, 16'h0055, 8);
        start_frame(4'd8, 1'b0);
        for (int i = 0; i < 7; i++) strobe(logic'((16'h00AA >> i) & 16'h1));
        check("hs_a_pending", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
        strobe(1'b1);
        data_ready = 1'b0;
        check("hs_p_data", 32'(p_data), 32'h0AA);
        check("hs_valid", 32'(data_valid), 32'd1);
        check("hs_no_ovr", 32'(overrun), 32'd0);
        consume("hs_consume");

        // abort after 3 bits, then a full frame
        start_frame(4'd8, 1'b0);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        check("abort_cnt", 32'(bit_cnt), 32'd3);
        start_frame(4'd8, 1'b0);
        check("abort_restart_cnt", 32'(bit_cnt), 32'd0);
        for (int i = 0; i < 7; i++) strobe(1'b1);
        check("abort_no_valid", 32'(data_valid), 32'd0);
        strobe(1'b1);
        check("abort_p_data", 32'(p_data), 32'h0FF);
        check("abort_valid", 32'(data_valid), 32'd1);
        consume("abort_consume");

        // frame_start coinciding with a strobe discards the bit
        start_frame(4'd3, 1'b0);
        strobe(1'b1);
        strobe(1'b1);
        frame_start = 1'b1;
        deser_en    = 1'b1;
        bit_in      = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        deser_en    = 1'b0;
        check("coll_cnt", 32'(bit_cnt), 32'd0);
        check("coll_busy", 32'(busy), 32'd1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        check("coll_p_data", 32'(p_data), 32'h006);
        consume("coll_consume");

        // asynchronous reset mid-frame with a word pending
        send(4'd8, 1'b0, 16'h0033, 8);
        start_frame(4'd8, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_p_data", 32'(p_data), 32'h0);
        check("arst_valid", 32'(data_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cnt", 32'(bit_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(4'd8, 1'b0, 16'h004D, 8);
        check("post_rst_p_data", 32'(p_data), 32'h04D);
        check("post_rst_valid", 32'(data_valid), 32'd1);
        consume("post_rst_consume");

        // length 0 clamps to a 1-bit frame
        send(4'd0, 1'b0, 16'h0001, 1);
        check("len0_p_data", 32'(p_data), 32'h001);
        check("len0_valid", 32'(data_valid), 32'd1);
        check("len0_cnt", 32'(bit_cnt), 32'd1);
        check("len0_par", 32'(par_calc), 32'(exp_par(16'h0001)));
        consume("len0_consume");

        // length 15 clamps to MAX_WIDTH
        start_frame(4'd15, 1'b0);
        for (int i = 0; i < 8; i++) strobe(logic'((16'h01A5 >> i) & 16'h1));
        check("len15_pre_valid", 32'(data_valid), 32'd0);
        check("len15_pre_busy", 32'(busy), 32'd1);
        strobe(1'b1);
        check("len15_p_data", 32'(p_data), 32'h1A5);
        check("len15_valid", 32'(data_valid), 32'd1);
        check("len15_cnt", 32'(bit_cnt), 32'd9);
        check("len15_par", 32'(par_calc), 32'(exp_par(16'h01A5)));
        consume("len15_consume");

        // 9-bit MSB-first
        send(4'd9, 1'b1, 16'h0001, 9);
        check("msb9_p_data", 32'(p_data), 32'h100);
        consume("msb9_consume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_deser_param.md
# rx_deser_param

Parametrised serial-to-parallel converter for the UART receive path. It sits between the bit sampler and the frame checker. It accumulates one sampled data bit per `deser_en` strobe into a frame whose length is chosen at run time, in either LSB-first or MSB-first order. It then presents the right-justified word through a valid/ready handshake, with overrun detection and an optional parity accumulator.

## Interface
- `MAX_WIDTH`, 9: maximum data bits per frame (legal range 2..16).
- `LEN_W`, `$clog2(MAX_WIDTH+1)`: width of the length and count fields.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sampled_data_bit` in 1: data bit from the sampler.
- `deser_en` in 1: one-cycle strobe meaning "accept `sampled_data_bit` now".
- `frame_start` in 1: one-cycle pulse that begins a new frame.
- `data_len` in `LEN_W`: bits per frame; latched at `frame_start`.
- `msb_first` in 1: bit order; latched at `frame_start`.
- `data_ready` in 1: consumer accepts `p_data`.
- `p_data` out `MAX_WIDTH`: right-justified received word; unused upper bits are 0.
- `data_valid` out 1: `p_data` holds an unconsumed word.
- `overrun` out 1: one-cycle pulse when an unconsumed word is overwritten.
- `busy` out 1: high in SHIFT.
- `bit_cnt` out `LEN_W`: number of bits accepted in the current frame.
- `par_calc` out 1: XOR of the data bits of the word in `p_data`.

## Operation
- States: IDLE, SHIFT. Internal registers: shift register `sreg[MAX_WIDTH]`, latched length `len_q`, latched order `ord_q`, running parity.
- IDLE:
  - `deser_en` is ignored.
  - On `frame_start`: go to SHIFT; `bit_cnt`=0, `sreg`=0, parity=0; latch `len_q` and `ord_q`.
- Length clamp applied at latch time: `data_len`=0 becomes 1; `data_len`>`MAX_WIDTH` becomes `MAX_WIDTH`.
- SHIFT, on `deser_en`:
  - LSB-first: `sreg[bit_cnt]` <= bit.
  - MSB-first: `sreg` <= {`sreg[MAX_WIDTH-2:0]`, bit}.
  - `bit_cnt`++ and parity ^= bit.
  - Either order yields a right-justified word with zero upper bits.
- Frame completion: on the strobe that accepts bit number `len_q`:
  - `p_data` is loaded with the final word, including that bit.
  - `data_valid`=1, `par_calc` is updated, state returns to IDLE.
- `frame_start` while in SHIFT: abort the current frame and restart (same actions as from IDLE). No word is produced and `p_data`/`data_valid` are untouched.
- `frame_start` together with `deser_en` in the same cycle: `frame_start` wins and the bit is discarded.
- Handshake:
  - `data_valid` clears on any edge where `data_valid`=1 and `data_ready`=1.
  - `p_data` holds its value until the next completion.
  - `data_ready` while `data_valid`=0 has no effect.
- Completion in the same cycle as the handshake: the old word counts as consumed, the new word is loaded, `data_valid` stays 1, and there is no overrun.
- Completion while `data_valid`=1 and `data_ready`=0: the new word overwrites `p_data`, `data_valid` stays 1, and `overrun`=1 for exactly one cycle.
- `rst` asserted mid-frame: immediately go to IDLE and zero all registers. No word is produced.

## Timing
- Reset values: `p_data`=0, `data_valid`=0, `overrun`=0, `busy`=0, `bit_cnt`=0, `par_calc`=0, state=IDLE.
- `busy` rises the cycle after `frame_start` and falls on the completion edge.
- Latency: `data_valid` and `p_data` are visible the cycle after the edge that sampled the last bit. Zero extra pipeline.
- Back-to-back frames are allowed: `frame_start` may arrive in the cycle right after completion.
- `deser_en` strobes may be spaced arbitrarily, with a minimum spacing of 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RX_DESER_PARITY_EN` defined: the parity XOR accumulator is built, and `par_calc` equals the XOR of the `len_q` received bits, updated with `p_data`.
- `RX_DESER_PARITY_EN` undefined: the parity logic is removed and `par_calc` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then `data_len`=8, LSB-first, bits 1,0,1,1,0,0,1,0 -> `p_data`=0x04D, `data_valid`=1 one cycle after the 8th strobe, `par_calc`=0 (macro on).
- Same bits with `msb_first`=1 -> `p_data`=0x0B2; `data_len`=5, LSB-first, bits 1,1,1,0,1 -> `p_data`=0x017, `par_calc`=0.
- Complete frame A (0x55), hold `data_ready`=0, complete frame B (0xAA) -> `p_data`=0x0AA, `data_valid`=1, one-cycle `overrun`. Repeat with `data_ready`=1 on B's completion edge -> no `overrun`.
- `frame_start` after 3 strobes, then 8 new bits 0xFF -> `p_data`=0x0FF with no intermediate valid. `frame_start` coinciding with `deser_en` -> that bit is discarded and `bit_cnt`=0.
- `rst` asserted mid-frame after 4 bits -> all outputs 0 asynchronously; the next full frame is received correctly. `data_len`=0 -> 1-bit frame; `data_len`=15 -> clamped to 9.
- Build without `RX_DESER_PARITY_EN`: rerun the first test -> `par_calc` stays 0 and `p_data` is unchanged.
